regfile_ctrl: RTL and testbench
===============================

REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; no other clock or reset SHALL exist.
REQ-002 clk  input  1  rising-edge clock shared with the 8x16 register file.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  command valid.
REQ-005 in_ready  output  1  command accepted at a rising edge when in_valid=1 and in_ready=1.
REQ-006 op  input  2  command opcode: 00 LOADI, 01 MOV, 10 ADD, 11 NOT.
REQ-007 rd, rs, rt  input  3 each  destination register, source A and source B.
REQ-008 imm  input  16  immediate value for LOADI.
REQ-009 done  output  1  high for the single cycle in which the result is written.
REQ-010 busy  output  1  equals ~in_ready.
REQ-011 rf_readnum  output  3  register file read select.
REQ-012 rf_writenum  output  3  register file write select.
REQ-013 rf_write  output  1  register file write enable.
REQ-014 rf_data_in  output  16  register file write data.
REQ-015 rf_data_out  input  16  combinational register file read data for rf_readnum.

Function
REQ-016 The FSM SHALL have the states IDLE, RDA, RDB and WR; in_ready SHALL be 1 only in IDLE.
REQ-017 On acceptance the block SHALL latch op, rd, rs, rt and imm, and the latched copies SHALL drive all later behaviour.
REQ-018 Transitions out of IDLE: LOADI->WR, MOV->RDA, NOT->RDA, ADD->RDA; without acceptance the FSM SHALL stay in IDLE.
REQ-019 Transitions: RDA->RDB for ADD, RDA->WR otherwise; RDB->WR; WR->IDLE unconditionally.
REQ-020 In RDA, rf_readnum SHALL equal rs, and the edge that ends RDA SHALL capture rf_data_out into an internal register A.
REQ-021 In RDB, rf_readnum SHALL equal rt, and the edge that ends RDB SHALL capture rf_data_out into B.
REQ-022 In all other states, rf_readnum SHALL be 0.
REQ-023 In WR, rf_write=1 and done=1, and in every other state both SHALL be 0.
REQ-024 rf_writenum SHALL equal the latched rd in every state.
REQ-025 rf_data_in in WR SHALL be: LOADI imm; MOV A; NOT ~A; ADD (A+B) mod 2^16, with the carry discarded from the data.
REQ-026 Busy cycles from acceptance to the return to IDLE SHALL be: LOADI 1, MOV 2, NOT 2, ADD 3.
REQ-027 The write SHALL commit at the edge that ends WR.
REQ-028 While busy, in_valid SHALL be ignored, and the producer SHALL hold the command until it is accepted.
REQ-029 For ADD with rs=rt, the block SHALL read the same register twice, so R+R SHALL be correct.
REQ-030 When rd equals rs or rt, the read SHALL use the old value, because every read precedes the write.
REQ-031 There SHALL be no back-to-back acceptance: the next command SHALL be accepted no earlier than the edge that ends the first IDLE cycle after WR.

Reset
REQ-032 On reset the FSM SHALL enter IDLE immediately, so that in_ready=1, busy=0, done=0 and rf_write=0.
REQ-033 On reset, rf_readnum=0 and rf_writenum=0, and the latches, A and B SHALL be cleared to 0.
REQ-034 Reset asserted mid-command SHALL abort it with no rf_write pulse, and the register file contents SHALL NOT be modified.

Configuration
REQ-035 With macro REGCTRL_STATUS_EN defined, the block SHALL add the outputs flag_z, flag_n and flag_c (1 bit each, reset 0).
REQ-036 With REGCTRL_STATUS_EN, the flags SHALL be registered at the edge ending WR: Z = (rf_data_in==0) and N = rf_data_in[15].
REQ-037 With REGCTRL_STATUS_EN, C SHALL be the ADD carry-out; LOADI, MOV and NOT SHALL clear C.
REQ-038 With REGCTRL_STATUS_EN, the flags SHALL hold their values at all other times.
REQ-039 Without REGCTRL_STATUS_EN, the flag ports and logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-040 Reset, then LOADI rd=3 imm=0x1234 -> in the next cycle rf_write=1, done=1, rf_writenum=3 and rf_data_in=0x1234, for exactly 1 cycle; in the following cycle in_ready=1.
REQ-041 LOADI R1=0x0005, LOADI R2=0x0007, then ADD rd=4 rs=1 rt=2 -> RDA with readnum=1, RDB with readnum=2, then WR with rf_data_in=0x000C; busy for 3 cycles.
REQ-042 LOADI R1=0xFFFF, LOADI R2=0x0001, then ADD rd=5 -> rf_data_in=0x0000; with the macro, flag_z=1, flag_c=1 and flag_n=0.
REQ-043 LOADI R0=0x00F0, then NOT rd=6 rs=0 -> rf_data_in=0xFF0F and N=1; MOV rd=1 rs=1 with R1=0xABCD -> writes 0xABCD.
REQ-044 Pulse in_valid with a LOADI during an ADD's RDA cycle -> the LOADI is not accepted, and only the ADD writes.
REQ-045 Assert reset in RDB of an ADD to R7 (R7=0x1111) -> no rf_write pulse, R7 stays 0x1111, and in_ready=1 during reset.

Source files
------------

// File: rtl/regfile_ctrl.sv
// regfile_ctrl: sequences single commands (LOADI, MOV, ADD, NOT) against an
// external 8x16 register file with a combinational read port.
// Each command reads its operands one per cycle, then writes the result once.
// Optional build macro: REGCTRL_STATUS_EN adds the Z/N/C status flag outputs.
module regfile_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [2:0]  rd,
    input  logic [2:0]  rs,
    input  logic [2:0]  rt,
    input  logic [15:0] imm,
    output logic        done,
    output logic        busy,
    output logic [2:0]  rf_readnum,
    output logic [2:0]  rf_writenum,
    output logic        rf_write,
    output logic [15:0] rf_data_in,
    input  logic [15:0] rf_data_out
`ifdef REGCTRL_STATUS_EN
    ,
    output logic        flag_z,
    output logic        flag_n,
    output logic        flag_c
`endif
);

    localparam logic [1:0] OP_LOADI = 2'b00;
    localparam logic [1:0] OP_MOV   = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_NOT   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RDA  = 2'd1,
        S_RDB  = 2'd2,
        S_WR   = 2'd3
    } state_t;

    state_t      state_q;
    logic        ready_q;
    logic        write_q;
    logic [2:0]  readnum_q;
    logic [1:0]  op_q;
    logic [2:0]  rd_q;
    logic [2:0]  rs_q;
    logic [2:0]  rt_q;
    logic [15:0] imm_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [15:0] result_d;

`ifdef REGCTRL_STATUS_EN
    logic [16:0] sum_d;
    logic        flag_z_q;
    logic        flag_n_q;
    logic        flag_c_q;
`else
    logic [15:0] sum_d;
`endif

    // Operand sum; the carry bit only exists when the status flags are built.
    always_comb begin
`ifdef REGCTRL_STATUS_EN
        sum_d = {1'b0, a_q} + {1'b0, b_q};
`else
        sum_d = a_q + b_q;
`endif
    end

    // Write data chosen from the latched opcode and the captured operands.
    always_comb begin
        result_d = imm_q;
        case (op_q)
            OP_LOADI: result_d = imm_q;
            OP_MOV:   result_d = a_q;
            OP_ADD:   result_d = sum_d[15:0];
            OP_NOT:   result_d = ~a_q;
            default:  result_d = imm_q;
        endcase
    end

    // Command FSM: state, registered handshake/strobe outputs, command latches and operand capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b1;
            write_q   <= 1'b0;
            readnum_q <= 3'd0;
            op_q      <= 2'd0;
            rd_q      <= 3'd0;
            rs_q      <= 3'd0;
            rt_q      <= 3'd0;
            imm_q     <= 16'd0;
            a_q       <= 16'd0;
            b_q       <= 16'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && ready_q) begin
                        op_q    <= op;
                        rd_q    <= rd;
                        rs_q    <= rs;
                        rt_q    <= rt;
                        imm_q   <= imm;
                        ready_q <= 1'b0;
                        if (op == OP_LOADI) begin
                            state_q   <= S_WR;
                            write_q   <= 1'b1;
                            readnum_q <= 3'd0;
                        end else begin
                            state_q   <= S_RDA;
                            write_q   <= 1'b0;
                            readnum_q <= rs;
                        end
                    end
                end
                S_RDA: begin
                    a_q <= rf_data_out;
                    if (op_q == OP_ADD) begin
                        state_q   <= S_RDB;
                        readnum_q <= rt_q;
                    end else begin
                        state_q   <= S_WR;
                        write_q   <= 1'b1;
                        readnum_q <= 3'd0;
                    end
                end
                S_RDB: begin
                    b_q       <= rf_data_out;
                    state_q   <= S_WR;
                    write_q   <= 1'b1;
                    readnum_q <= 3'd0;
                end
                S_WR: begin
                    state_q   <= S_IDLE;
                    write_q   <= 1'b0;
                    ready_q   <= 1'b1;
                    readnum_q <= 3'd0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    write_q   <= 1'b0;
                    ready_q   <= 1'b1;
                    readnum_q <= 3'd0;
                end
            endcase
        end
    end

`ifdef REGCTRL_STATUS_EN
    // Status flags update only on the edge that commits the write, otherwise they hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else if (state_q == S_WR) begin
            flag_z_q <= (result_d == 16'd0);
            flag_n_q <= result_d[15];
            flag_c_q <= (op_q == OP_ADD) ? sum_d[16] : 1'b0;
        end
    end

    assign flag_z = flag_z_q;
    assign flag_n = flag_n_q;
    assign flag_c = flag_c_q;
`endif

    assign in_ready    = ready_q;
    assign busy        = ~ready_q;
    assign done        = write_q;
    assign rf_write    = write_q;
    assign rf_readnum  = readnum_q;
    assign rf_writenum = rd_q;
    assign rf_data_in  = result_d;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Self-checking bench for regfile_ctrl with a behavioural 8x16 register file.
module tb_regfile_ctrl;

    localparam logic [1:0] OP_LOADI = 2'b00;
    localparam logic [1:0] OP_MOV   = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_NOT   = 2'b11;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [15:0] imm;
    logic        done;
    logic        busy;
    logic [2:0]  rf_readnum;
    logic [2:0]  rf_writenum;
    logic        rf_write;
    logic [15:0] rf_data_in;
    logic [15:0] rf_data_out;
`ifdef REGCTRL_STATUS_EN
    logic        flag_z;
    logic        flag_n;
    logic        flag_c;
`endif

    logic [15:0] rf_mem [0:7];
    int          n_checks;
    int          n_fail;
    int          wr_pulses;

    regfile_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .rd          (rd),
        .rs          (rs),
        .rt          (rt),
        .imm         (imm),
        .done        (done),
        .busy        (busy),
        .rf_readnum  (rf_readnum),
        .rf_writenum (rf_writenum),
        .rf_write    (rf_write),
        .rf_data_in  (rf_data_in),
        .rf_data_out (rf_data_out)
`ifdef REGCTRL_STATUS_EN
        ,
        .flag_z      (flag_z),
        .flag_n      (flag_n),
        .flag_c      (flag_c)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: combinational read, write on the rising edge.
    assign rf_data_out = rf_mem[rf_readnum];
    always @(posedge clk) begin
        if (rf_write) rf_mem[rf_writenum] <= rf_data_in;
    end
    always @(posedge clk) begin
        if (rf_write) wr_pulses <= wr_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one command and follow it to the return to IDLE. Optionally pulse a
    // LOADI R7 during the first busy cycle, which must be ignored.
    task automatic do_cmd(input logic [1:0] o, input logic [2:0] d, input logic [2:0] s,
                          input logic [2:0] t, input logic [15:0] im,
                          input int exp_cycles, input logic [15:0] exp_data, input bit inject);
        int cyc;
        int writes;
        logic [2:0] exp_rn;
        @(negedge clk);
        check("ready_before_accept", in_ready, 1'b1);
        in_valid = 1'b1; op = o; rd = d; rs = s; rt = t; imm = im;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        writes = 0;
        while (busy && cyc < 10) begin
            if (rf_write) begin
                exp_rn = 3'd0;
                writes++;
                check("wdata", rf_data_in, exp_data);
                check("writenum", rf_writenum, d);
                check("done_in_wr", done, 1'b1);
            end else if (cyc == 0) begin
                exp_rn = s;
            end else begin
                exp_rn = t;
            end
            check("readnum", rf_readnum, exp_rn);
            if (inject && cyc == 0) begin
                in_valid = 1'b1; op = OP_LOADI; rd = 3'd7; imm = 16'hDEAD;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            cyc++;
        end
        check("busy_cycles", cyc, exp_cycles);
        check("write_count", writes, 1);
        check("ready_after", in_ready, 1'b1);
        check("done_after", done, 1'b0);
        $display("cmd op=%0d rd=%0d rs=%0d rt=%0d imm=%04h -> cycles=%0d data=%04h",
                 o, d, s, t, im, cyc, rf_mem[d]);
    endtask

    initial begin
        int pulses_before;
        n_checks = 0;
        n_fail = 0;
        wr_pulses = 0;
        for (int i = 0; i < 8; i++) rf_mem[i] = 16'h0000;
        in_valid = 1'b0; op = 2'd0; rd = 3'd0; rs = 3'd0; rt = 3'd0; imm = 16'h0000;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_write", rf_write, 1'b0);
        check("rst_readnum", rf_readnum, 3'd0);
        check("rst_writenum", rf_writenum, 3'd0);
`ifdef REGCTRL_STATUS_EN
        check("rst_flags", {flag_z, flag_n, flag_c}, 3'b000);
`endif
        @(negedge clk);
        reset = 1'b0;
        $display("reset released");

        do_cmd(OP_LOADI, 3'd3, 3'd0, 3'd0, 16'h1234, 1, 16'h1234, 1'b0);
        check("r3", rf_mem[3], 16'h1234);

        do_cmd(OP_LOADI, 3'd1, 3'd0, 3'd0, 16'h0005, 1, 16'h0005, 1'b0);
        do_cmd(OP_LOADI, 3'd2, 3'd0, 3'd0, 16'h0007, 1, 16'h0007, 1'b0);
        do_cmd(OP_ADD,   3'd4, 3'd1, 3'd2, 16'h0000, 3, 16'h000C, 1'b0);
        check("r4_add", rf_mem[4], 16'h000C);

        do_cmd(OP_LOADI, 3'd1, 3'd0, 3'd0, 16'hFFFF, 1, 16'hFFFF, 1'b0);
        do_cmd(OP_LOADI, 3'd2, 3'd0, 3'd0, 16'h0001, 1, 16'h0001, 1'b0);
        do_cmd(OP_ADD,   3'd5, 3'd1, 3'd2, 16'h0000, 3, 16'h0000, 1'b0);
`ifdef REGCTRL_STATUS_EN
        check("flags_add_wrap", {flag_z, flag_n, flag_c}, 3'b101);
`endif

        do_cmd(OP_LOADI, 3'd0, 3'd0, 3'd0, 16'h00F0, 1, 16'h00F0, 1'b0);
        do_cmd(OP_NOT,   3'd6, 3'd0, 3'd0, 16'h0000, 2, 16'hFF0F, 1'b0);
`ifdef REGCTRL_STATUS_EN
        check("flags_not", {flag_z, flag_n, flag_c}, 3'b010);
`endif

        do_cmd(OP_LOADI, 3'd1, 3'd0, 3'd0, 16'hABCD, 1, 16'hABCD, 1'b0);
        do_cmd(OP_MOV,   3'd1, 3'd1, 3'd0, 16'h0000, 2, 16'hABCD, 1'b0);
        check("r1_mov", rf_mem[1], 16'hABCD);

        // rs == rt reads the same register twice: R2 = 1 + 1.
        do_cmd(OP_ADD, 3'd2, 3'd2, 3'd2, 16'h0000, 3, 16'h0002, 1'b0);
        // rd == rs uses the old value: R3 = 0x1234 + 2.
        do_cmd(OP_ADD, 3'd3, 3'd3, 3'd2, 16'h0000, 3, 16'h1236, 1'b0);
        check("r3_add_self", rf_mem[3], 16'h1236);

        // LOADI R7 pulsed during RDA of ADD R4 = R1 + R0 must be ignored.
        do_cmd(OP_ADD, 3'd4, 3'd1, 3'd0, 16'h0000, 3, 16'hACBD, 1'b1);
        check("r7_untouched", rf_mem[7], 16'h0000);
        check("r4_inject", rf_mem[4], 16'hACBD);

        // Reset during RDB of ADD R7 aborts with no write.
        do_cmd(OP_LOADI, 3'd7, 3'd0, 3'd0, 16'h1111, 1, 16'h1111, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; op = OP_ADD; rd = 3'd7; rs = 3'd1; rt = 3'd0; imm = 16'h0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("abort_rda_readnum", rf_readnum, 3'd1);
        @(posedge clk); #1;
        check("abort_rdb_readnum", rf_readnum, 3'd0);
        pulses_before = wr_pulses;
        reset = 1'b1;
        #1;
        check("abort_ready", in_ready, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_write", rf_write, 1'b0);
        check("abort_writenum", rf_writenum, 3'd0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_ready_held", in_ready, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_pulse", wr_pulses, pulses_before);
        check("abort_r7", rf_mem[7], 16'h1111);
        $display("reset abort: r7=%04h pulses=%0d", rf_mem[7], wr_pulses - pulses_before);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
